// File: rtl/pixel_packet_framer_if.sv
// Bundle of pixel-timing inputs, payload request handshake and framed pixel output
// for pixel_packet_framer; the source/timing side uses master, the framer uses slave.
interface pixel_packet_framer_if #(
    parameter int DLEN_MAX = 43,
    parameter int OUT_W    = 64,
    parameter int XY_W     = 10
);
    logic [XY_W-1:0]       x;
    logic [XY_W-1:0]       y;
    logic                  pixel_de;
    logic                  req;
    logic [15:0]           req_len;
    logic [7:0]            req_type;
    logic [DLEN_MAX*8-1:0] req_data;
    logic                  req_ack;
    logic                  req_err;
    logic                  busy;
    logic                  done;
    logic [OUT_W-1:0]      pixel_value;

    modport master (
        output x, y, pixel_de, req, req_len, req_type, req_data,
        input  req_ack, req_err, busy, done, pixel_value
    );

    modport slave (
        input  x, y, pixel_de, req, req_len, req_type, req_data,
        output req_ack, req_err, busy, done, pixel_value
    );
endinterface

// File: rtl/pixel_packet_framer.sv
// Frames a variable-length payload (SOF, header, payload, XOR checksum, EOF) and
// serialises it as BEAT_BYTES-wide beats into the active video, one packet per frame.
module pixel_packet_framer #(
    parameter int         DLEN_MAX   = 43,
    parameter int         BEAT_BYTES = 6,
    parameter int         OUT_W      = 64,
    parameter int         H_ACTIVE   = 640,
    parameter int         V_ACTIVE   = 480,
    parameter int         XY_W       = 10,
    parameter logic [7:0] PHL_ID     = 8'h00
) (
    input  logic                  tx_pixel_clk,
    input  logic                  tx_pixel_rstn,
    pixel_packet_framer_if.slave  bus
);
    localparam int          DI_W      = (DLEN_MAX > 1) ? $clog2(DLEN_MAX) : 1;
    localparam logic [31:0] PIX_TOTAL = 32'(H_ACTIVE * V_ACTIVE);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_PAD   = 2'd3;

    logic [1:0]       r_state;
    logic [15:0]      r_len;
    logic [7:0]       r_type;
    logic [7:0]       r_data [DLEN_MAX];
    logic [16:0]      r_idx;
    logic [7:0]       r_chk;
    logic             r_ack;
    logic             r_err;
    logic             r_busy;
    logic             r_done;
    logic [OUT_W-1:0] r_pix;

    logic [16:0]      w_req_n;
    logic [31:0]      w_req_beats;
    logic             w_req_ok;
    logic             w_accept;
    logic [16:0]      w_n;
    logic             w_last;
    logic             w_frame_start;
    logic             w_final;
    logic [OUT_W-1:0] w_beat;
    logic [7:0]       w_chk_next;

    // Length and whole-packet-fits-in-one-frame checks on the live request.
    assign w_req_n     = {1'b0, bus.req_len} + 17'd9;
    assign w_req_beats = 32'((w_req_n + 17'(BEAT_BYTES - 1)) / 17'(BEAT_BYTES));
    assign w_req_ok    = (bus.req_len != 16'd0) && (bus.req_len <= 16'(DLEN_MAX))
                         && (w_req_beats <= PIX_TOTAL);
    assign w_accept    = (r_state == S_IDLE) && bus.req && w_req_ok;

    assign w_n           = {1'b0, r_len} + 17'd9;
    assign w_last        = (r_idx + 17'(BEAT_BYTES)) >= w_n;
    assign w_frame_start = bus.pixel_de && (bus.x == '0) && (bus.y == '0);
    assign w_final       = bus.pixel_de && (bus.x == XY_W'(H_ACTIVE - 1))
                           && (bus.y == XY_W'(V_ACTIVE - 1));

    // Beat assembly; the checksum chain runs lane by lane so CHK sees every
    // payload byte emitted earlier in the same beat.
    always_comb begin
        logic [16:0]     v_k;
        logic [DI_W-1:0] v_d;
        logic [7:0]      v_chk;
        logic [7:0]      v_byte;
        logic            v_pay;
        w_beat = '0;
        v_chk  = r_chk;
        v_k    = '0;
        v_d    = '0;
        v_byte = 8'h00;
        v_pay  = 1'b0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            v_k    = r_idx + 17'(i);
            v_d    = DI_W'(v_k - 17'd6);
            v_pay  = (v_k >= 17'd6) && (v_k < ({1'b0, r_len} + 17'd6));
            v_byte = 8'h00;
            if (v_k == 17'd0)                           v_byte = 8'hEA;
            else if (v_k == 17'd1)                      v_byte = 8'hFF;
            else if (v_k == 17'd2)                      v_byte = PHL_ID;
            else if (v_k == 17'd3)                      v_byte = r_type;
            else if (v_k == 17'd4)                      v_byte = r_len[7:0];
            else if (v_k == 17'd5)                      v_byte = r_len[15:8];
            else if (v_pay)                             v_byte = r_data[v_d];
            else if (v_k == {1'b0, r_len} + 17'd6)      v_byte = v_chk;
            else if (v_k == {1'b0, r_len} + 17'd7)      v_byte = 8'hDD;
            else if (v_k == {1'b0, r_len} + 17'd8)      v_byte = 8'hAA;
            if (v_pay) v_chk = v_chk ^ v_byte;
            w_beat[8*i +: 8] = v_byte;
        end
        w_chk_next = v_chk;
    end

    for (genvar gi = 0; gi < DLEN_MAX; gi++) begin : g_data
        always_ff @(posedge tx_pixel_clk or negedge tx_pixel_rstn) begin
            if (!tx_pixel_rstn)
                r_data[gi] <= 8'h00;
            else if (w_accept)
                r_data[gi] <= bus.req_data[8*gi +: 8];
        end
    end

    always_ff @(posedge tx_pixel_clk or negedge tx_pixel_rstn) begin
        if (!tx_pixel_rstn) begin
            r_state <= S_IDLE;
            r_len   <= 16'd0;
            r_type  <= 8'h00;
            r_idx   <= 17'd0;
            r_chk   <= 8'h00;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pix   <= '0;
        end else begin
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_done <= 1'b0;
            r_pix  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        if (w_req_ok) begin
                            r_len   <= bus.req_len;
                            r_type  <= bus.req_type;
                            r_idx   <= 17'd0;
                            r_chk   <= 8'h00;
                            r_ack   <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= S_ARMED;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_ARMED, S_SEND: begin
                    if ((r_state == S_ARMED) ? w_frame_start : bus.pixel_de) begin
                        r_pix <= w_beat;
                        r_chk <= w_chk_next;
                        if (!w_last) begin
                            r_idx   <= r_idx + 17'(BEAT_BYTES);
                            r_state <= S_SEND;
                        end else if (w_final) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_PAD;
                        end
                    end
                end
                default: begin
                    if (w_final) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.req_ack     = r_ack;
    assign bus.req_err     = r_err;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.pixel_value = r_pix;
endmodule

// File: tb/tb_pixel_packet_framer.sv
// Directed bench for pixel_packet_framer on a small 4x4 raster with line and frame
// blanking; expected beats are hand-computed byte lanes.
module tb_pixel_packet_framer;
    localparam int DL = 43;
    localparam int OW = 64;
    localparam int XW = 10;
    localparam int H  = 4;
    localparam int V  = 4;
    localparam int HB = 2;
    localparam int VB = 1;
    localparam int FINAL_CI = (V - 1) * (H + HB) + (H - 1);

    // len=4, type=01, data 01..04, CHK=04
    localparam logic [63:0] T1_B0 = 64'h0000_0004_0100_FFEA;
    localparam logic [63:0] T1_B1 = 64'h0000_DD04_0403_0201;
    localparam logic [63:0] T1_B2 = 64'h0000_0000_0000_00AA;
    // len=43, type=22, data 10..3A, CHK=3B
    localparam logic [63:0] T2_B0 = 64'h0000_002B_2200_FFEA;
    localparam logic [63:0] T2_B1 = 64'h0000_1514_1312_1110;
    localparam logic [63:0] T2_B4 = 64'h0000_2726_2524_2322;
    localparam logic [63:0] T2_B7 = 64'h0000_3938_3736_3534;
    localparam logic [63:0] T2_B8 = 64'h0000_AADD_3B3A;
    // 8-byte beats, len=7, type=05, data 01..07, CHK=00
    localparam logic [63:0] T6_B0 = 64'h0201_0007_0500_FFEA;
    localparam logic [63:0] T6_B1 = 64'hAADD_0007_0605_0403;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [XW-1:0]   t_x, t_y;
    logic            t_de, t_req;
    logic [1:0]      t_sel;
    logic [15:0]     t_len;
    logic [7:0]      t_type;
    logic [DL*8-1:0] t_data;

    pixel_packet_framer_if #(.DLEN_MAX(DL), .OUT_W(OW), .XY_W(XW)) bus6 ();
    pixel_packet_framer_if #(.DLEN_MAX(DL), .OUT_W(OW), .XY_W(XW)) bus8 ();
    pixel_packet_framer_if #(.DLEN_MAX(DL), .OUT_W(OW), .XY_W(XW)) busv ();

    assign bus6.x = t_x;  assign bus6.y = t_y;  assign bus6.pixel_de = t_de;
    assign bus8.x = t_x;  assign bus8.y = t_y;  assign bus8.pixel_de = t_de;
    assign busv.x = '0;   assign busv.y = '0;   assign busv.pixel_de = 1'b0;
    assign bus6.req = t_req && (t_sel == 2'd0);
    assign bus8.req = t_req && (t_sel == 2'd1);
    assign busv.req = t_req && (t_sel == 2'd2);
    assign bus6.req_len = t_len;  assign bus6.req_type = t_type;  assign bus6.req_data = t_data;
    assign bus8.req_len = t_len;  assign bus8.req_type = t_type;  assign bus8.req_data = t_data;
    assign busv.req_len = t_len;  assign busv.req_type = t_type;  assign busv.req_data = t_data;

    pixel_packet_framer #(.DLEN_MAX(DL), .BEAT_BYTES(6), .OUT_W(OW), .H_ACTIVE(H),
                          .V_ACTIVE(V), .XY_W(XW), .PHL_ID(8'h00))
        u_dut6 (.tx_pixel_clk(clk), .tx_pixel_rstn(rst_n), .bus(bus6.slave));
    pixel_packet_framer #(.DLEN_MAX(DL), .BEAT_BYTES(8), .OUT_W(OW), .H_ACTIVE(H),
                          .V_ACTIVE(V), .XY_W(XW), .PHL_ID(8'h00))
        u_dut8 (.tx_pixel_clk(clk), .tx_pixel_rstn(rst_n), .bus(bus8.slave));
    // 2x2 raster holds only 4 beats: len 15 fits, len 16 does not.
    pixel_packet_framer #(.DLEN_MAX(DL), .BEAT_BYTES(6), .OUT_W(OW), .H_ACTIVE(2),
                          .V_ACTIVE(2), .XY_W(XW), .PHL_ID(8'h00))
        u_dutv (.tx_pixel_clk(clk), .tx_pixel_rstn(rst_n), .bus(busv.slave));

    int checks = 0;
    int failures = 0;
    logic [63:0] cap6 [H*V];
    logic [63:0] cap8 [H*V];
    int done6_at, done8_at, gap_bad;
    logic r_ack, r_err, r_busy;

    task automatic set_data(input int n, input int base);
        t_data = '0;
        for (int j = 0; j < n; j++) t_data[8*j +: 8] = 8'(base + j);
    endtask

    task automatic do_req(input logic [1:0] sel, input logic [15:0] len, input logic [7:0] typ);
        t_sel = sel; t_len = len; t_type = typ; t_req = 1'b1;
        @(negedge clk);
        case (sel)
            2'd0:    begin r_ack = bus6.req_ack; r_err = bus6.req_err; r_busy = bus6.busy; end
            2'd1:    begin r_ack = bus8.req_ack; r_err = bus8.req_err; r_busy = bus8.busy; end
            default: begin r_ack = busv.req_ack; r_err = busv.req_err; r_busy = busv.busy; end
        endcase
        t_req = 1'b0;
        $display("req sel=%0d len=%0d type=%h -> ack=%b err=%b busy=%b", sel, len, typ, r_ack, r_err, r_busy);
    endtask

    task automatic run_frame(input int req_pix, output logic ack_seen);
        int ci = 0;
        ack_seen = 1'b0; done6_at = -1; done8_at = -1; gap_bad = 0;
        for (int line = 0; line < V + VB; line++) begin
            for (int col = 0; col < H + HB; col++) begin
                t_de  = (line < V) && (col < H);
                t_x   = XW'(col);
                t_y   = XW'(line);
                t_req = (ci == req_pix);
                @(negedge clk);
                if (t_de) begin
                    cap6[line*H + col] = bus6.pixel_value;
                    cap8[line*H + col] = bus8.pixel_value;
                end else if (bus6.pixel_value != 0 || bus8.pixel_value != 0) begin
                    gap_bad++;
                end
                if (bus6.done) done6_at = ci;
                if (bus8.done) done8_at = ci;
                if (t_req) ack_seen = (t_sel == 2'd0) ? bus6.req_ack : bus8.req_ack;
                ci++;
            end
        end
        t_de = 1'b0; t_req = 1'b0; t_x = '0; t_y = '0;
        $display("frame req_pix=%0d ack=%b done6_at=%0d done8_at=%0d gap_nonzero=%0d",
                 req_pix, ack_seen, done6_at, done8_at, gap_bad);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus6.req_ack, bus6.req_err, bus6.busy, bus6.done} !== 4'b0000 || bus6.pixel_value !== 64'd0) begin
            failures++;
            $display("FAIL reset_outputs got ack/err/busy/done=%b%b%b%b pix=%h required 0000 pix=0",
                     bus6.req_ack, bus6.req_err, bus6.busy, bus6.done, bus6.pixel_value);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reject();
        for (int i = 0; i < 2; i++) begin
            do_req(2'd0, (i == 0) ? 16'd0 : 16'd44, 8'h01);
            checks++;
            if ({r_ack, r_err, r_busy} !== 3'b010) begin
                failures++;
                $display("FAIL reject_len_%0d got ack/err/busy=%b%b%b required 010", i, r_ack, r_err, r_busy);
            end
            @(negedge clk);
            checks++;
            if (bus6.req_err !== 1'b0 || bus6.busy !== 1'b0 || bus6.pixel_value !== 64'd0) begin
                failures++;
                $display("FAIL reject_after_%0d got err=%b busy=%b pix=%h required 0 0 0",
                         i, bus6.req_err, bus6.busy, bus6.pixel_value);
            end
        end
        do_req(2'd2, 16'd16, 8'h01);
        checks++;
        if ({r_ack, r_err} !== 2'b01) begin
            failures++;
            $display("FAIL frame_budget_over got ack/err=%b%b required 01", r_ack, r_err);
        end
        @(negedge clk);
        do_req(2'd2, 16'd15, 8'h01);
        checks++;
        if ({r_ack, r_err, r_busy} !== 3'b101) begin
            failures++;
            $display("FAIL frame_budget_fit got ack/err/busy=%b%b%b required 101", r_ack, r_err, r_busy);
        end
    endtask

    task automatic test_short_packet();
        logic ack;
        set_data(4, 1);
        do_req(2'd0, 16'd4, 8'h01);
        checks++;
        if ({r_ack, r_err, r_busy} !== 3'b101) begin
            failures++;
            $display("FAIL short_accept got ack/err/busy=%b%b%b required 101", r_ack, r_err, r_busy);
        end
        run_frame(-1, ack);
        checks++;
        if (cap6[0] !== T1_B0 || cap6[1] !== T1_B1 || cap6[2] !== T1_B2 || cap6[3] !== 64'd0) begin
            failures++;
            $display("FAIL short_beats got %h %h %h %h required %h %h %h 0",
                     cap6[0], cap6[1], cap6[2], cap6[3], T1_B0, T1_B1, T1_B2);
        end
        checks++;
        if (done6_at !== FINAL_CI || gap_bad !== 0 || bus6.busy !== 1'b0) begin
            failures++;
            $display("FAIL short_done got done_at=%0d gap=%0d busy=%b required %0d 0 0",
                     done6_at, gap_bad, bus6.busy, FINAL_CI);
        end
    endtask

    task automatic test_max_len();
        logic ack;
        int nz;
        set_data(DL, 16'h10);
        do_req(2'd0, 16'd43, 8'h22);
        checks++;
        if (r_ack !== 1'b1) begin
            failures++;
            $display("FAIL max_accept got ack=%b required 1", r_ack);
        end
        run_frame(-1, ack);
        checks++;
        if (cap6[0] !== T2_B0 || cap6[1] !== T2_B1 || cap6[7] !== T2_B7 || cap6[8] !== T2_B8) begin
            failures++;
            $display("FAIL max_beats got %h %h %h %h required %h %h %h %h",
                     cap6[0], cap6[1], cap6[7], cap6[8], T2_B0, T2_B1, T2_B7, T2_B8);
        end
        checks++;
        if (cap6[4] !== T2_B4) begin
            failures++;
            $display("FAIL max_gap_hold got %h required %h", cap6[4], T2_B4);
        end
        nz = 0;
        for (int p = 9; p < H*V; p++) if (cap6[p] != 0) nz++;
        checks++;
        if (nz !== 0 || done6_at !== FINAL_CI) begin
            failures++;
            $display("FAIL max_pad got nonzero_pad=%0d done_at=%0d required 0 %0d", nz, done6_at, FINAL_CI);
        end
    endtask

    task automatic test_midframe_request();
        logic ack;
        int nz;
        set_data(4, 1);
        t_sel = 2'd0; t_len = 16'd4; t_type = 8'h01;
        run_frame(1 * (H + HB) + 2, ack);
        nz = 0;
        for (int p = 0; p < H*V; p++) if (cap6[p] != 0) nz++;
        checks++;
        if (ack !== 1'b1 || nz !== 0 || bus6.busy !== 1'b1) begin
            failures++;
            $display("FAIL midframe_wait got ack=%b beats=%0d busy=%b required 1 0 1", ack, nz, bus6.busy);
        end
        run_frame(-1, ack);
        checks++;
        if (cap6[0] !== T1_B0 || cap6[1] !== T1_B1 || cap6[2] !== T1_B2 || done6_at !== FINAL_CI) begin
            failures++;
            $display("FAIL midframe_send got %h %h %h done_at=%0d required %h %h %h %0d",
                     cap6[0], cap6[1], cap6[2], done6_at, T1_B0, T1_B1, T1_B2, FINAL_CI);
        end
    endtask

    task automatic test_full_beats();
        logic ack;
        set_data(7, 1);
        do_req(2'd1, 16'd7, 8'h05);
        run_frame(-1, ack);
        checks++;
        if (cap8[0] !== T6_B0 || cap8[1] !== T6_B1 || cap8[2] !== 64'd0) begin
            failures++;
            $display("FAIL full_beats got %h %h %h required %h %h 0", cap8[0], cap8[1], cap8[2], T6_B0, T6_B1);
        end
        checks++;
        if (done8_at !== FINAL_CI || bus8.busy !== 1'b0) begin
            failures++;
            $display("FAIL full_done got done_at=%0d busy=%b required %0d 0", done8_at, bus8.busy, FINAL_CI);
        end
    endtask

    task automatic test_reset_mid_send();
        logic ack;
        set_data(4, 1);
        do_req(2'd0, 16'd4, 8'h01);
        t_de = 1'b1; t_x = '0; t_y = '0;
        @(negedge clk);
        checks++;
        if (bus6.pixel_value !== T1_B0) begin
            failures++;
            $display("FAIL abort_first_beat got %h required %h", bus6.pixel_value, T1_B0);
        end
        t_x = XW'(1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus6.busy !== 1'b0 || bus6.pixel_value !== 64'd0) begin
            failures++;
            $display("FAIL abort_reset got busy=%b pix=%h required 0 0", bus6.busy, bus6.pixel_value);
        end
        t_de = 1'b0; t_x = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_req(2'd0, 16'd4, 8'h01);
        run_frame(-1, ack);
        checks++;
        if (r_ack !== 1'b1 || cap6[0] !== T1_B0 || cap6[1] !== T1_B1 || cap6[2] !== T1_B2) begin
            failures++;
            $display("FAIL abort_fresh got ack=%b %h %h %h required 1 %h %h %h",
                     r_ack, cap6[0], cap6[1], cap6[2], T1_B0, T1_B1, T1_B2);
        end
    endtask

    initial begin
        t_x = '0; t_y = '0; t_de = 1'b0; t_req = 1'b0; t_sel = 2'd0;
        t_len = '0; t_type = '0; t_data = '0;
        test_reset();
        test_reject();
        test_short_packet();
        test_max_len();
        test_midframe_request();
        test_full_beats();
        test_reset_mid_send();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
